// File: rtl/mm_host_master.sv
// mm_host_master: initiator for the 8-bit address / 32-bit data register bus.
// Host commands arrive on a valid/ready port, read data returns on a valid/ready port.
// Optional periodic status polling is compiled in when MM_AUTOPOLL_EN is defined;
// without it the stat_* outputs are tied to zero and only host states exist.
module mm_host_master #(
  parameter int unsigned POLL_PERIOD = 1000,
  parameter logic [7:0]  STAT_ADDR_A = 8'h01,
  parameter logic [7:0]  STAT_ADDR_B = 8'h02
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [7:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        mm_write_en,
  output logic        mm_read_en,
  output logic [7:0]  mm_addr,
  output logic [31:0] mm_wdata,
  input  logic [31:0] mm_rdata,
  output logic [1:0]  stat_active_channel,
  output logic [3:0]  stat_signal_present,
  output logic [31:0] stat_err_counts,
  output logic        stat_update,
  output logic        busy
);

`ifdef MM_AUTOPOLL_EN
  typedef enum logic [3:0] {
    StIdle, StWr, StRd, StRdCap, StResp, StPollA, StPollACap, StPollB, StPollBCap
  } state_e;
`else
  typedef enum logic [2:0] {StIdle, StWr, StRd, StRdCap, StResp} state_e;
`endif

  state_e      state_q, state_d;
  logic        cmd_ready_q, busy_q;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        mm_write_en_q, mm_read_en_q, rd_stb_d;
  logic [7:0]  mm_addr_q, mm_addr_d;
  logic [31:0] mm_wdata_q, mm_wdata_d;
  logic        poll_pending, poll_pending_d;

`ifdef MM_AUTOPOLL_EN
  localparam int unsigned CntW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(POLL_PERIOD - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [5:0]      stat_hold_q, stat_hold_d, stat_a_q, stat_a_d;
  logic [31:0]     stat_b_q, stat_b_d;
  logic            stat_update_q;

  // Poll counter: free-runs to saturation, cleared as the poll sequence starts
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StIdle && poll_pending) begin
      cnt_d = '0;
    end else if (cnt_q != LastCnt) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign poll_pending   = (cnt_q == LastCnt);
  assign poll_pending_d = (cnt_d == LastCnt);
`else
  assign poll_pending   = 1'b0;
  assign poll_pending_d = 1'b0;
`endif

  // Next-state and next-value logic for the transaction FSM
  always_comb begin
    state_d     = state_q;
    mm_addr_d   = mm_addr_q;
    mm_wdata_d  = mm_wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
`ifdef MM_AUTOPOLL_EN
    stat_hold_d = stat_hold_q;
    stat_a_d    = stat_a_q;
    stat_b_d    = stat_b_q;
`endif
    unique case (state_q)
      StIdle: begin
        // A due poll wins over a host command offered in the same cycle
        if (poll_pending) begin
`ifdef MM_AUTOPOLL_EN
          state_d   = StPollA;
          mm_addr_d = STAT_ADDR_A;
`endif
        end else if (cmd_valid && cmd_ready_q) begin
          mm_addr_d  = cmd_addr;
          mm_wdata_d = cmd_wdata;
          state_d    = cmd_write ? StWr : StRd;
        end
      end
      StWr:    state_d = StIdle;
      StRd:    state_d = StRdCap;
      StRdCap: begin
        rsp_rdata_d = mm_rdata;
        rsp_valid_d = 1'b1;
        state_d     = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
`ifdef MM_AUTOPOLL_EN
      StPollA:    state_d = StPollACap;
      StPollACap: begin
        // Word A is held back so both cached words change on the same edge
        stat_hold_d = mm_rdata[5:0];
        mm_addr_d   = STAT_ADDR_B;
        state_d     = StPollB;
      end
      StPollB:    state_d = StPollBCap;
      StPollBCap: begin
        stat_a_d = stat_hold_q;
        stat_b_d = mm_rdata;
        state_d  = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase

    rd_stb_d = (state_d == StRd);
`ifdef MM_AUTOPOLL_EN
    rd_stb_d = rd_stb_d || (state_d == StPollA) || (state_d == StPollB);
`endif
  end

  // State and registered host/bus outputs, all derived from the next state
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= StIdle;
      cmd_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      mm_write_en_q <= 1'b0;
      mm_read_en_q  <= 1'b0;
      mm_addr_q     <= '0;
      mm_wdata_q    <= '0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= (state_d == StIdle) && !poll_pending_d;
      busy_q        <= (state_d != StIdle);
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      mm_write_en_q <= (state_d == StWr);
      mm_read_en_q  <= rd_stb_d;
      mm_addr_q     <= mm_addr_d;
      mm_wdata_q    <= mm_wdata_d;
    end
  end

`ifdef MM_AUTOPOLL_EN
  // Poll counter and cached status registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q         <= '0;
      stat_hold_q   <= '0;
      stat_a_q      <= '0;
      stat_b_q      <= '0;
      stat_update_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      stat_hold_q   <= stat_hold_d;
      stat_a_q      <= stat_a_d;
      stat_b_q      <= stat_b_d;
      stat_update_q <= (state_q == StPollBCap);
    end
  end

  assign stat_active_channel = stat_a_q[1:0];
  assign stat_signal_present = stat_a_q[5:2];
  assign stat_err_counts     = stat_b_q;
  assign stat_update         = stat_update_q;
`else
  logic unused_poll_params;
  assign unused_poll_params  = ^{POLL_PERIOD, STAT_ADDR_A, STAT_ADDR_B};
  assign stat_active_channel = '0;
  assign stat_signal_present = '0;
  assign stat_err_counts     = '0;
  assign stat_update         = 1'b0;
`endif

  assign cmd_ready   = cmd_ready_q;
  assign busy        = busy_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign mm_write_en = mm_write_en_q;
  assign mm_read_en  = mm_read_en_q;
  assign mm_addr     = mm_addr_q;
  assign mm_wdata    = mm_wdata_q;

endmodule
